// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, frame-locked arbiter sharing one UART transmitter
//            between NUM_REQ requesters. The owner keeps the transmitter until
//            it sends a byte flagged last, or until it withholds its next byte
//            for IDLE_TIMEOUT cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   NUM_REQ      : number of requesters (2..16)
//   IDLE_TIMEOUT : cycles the owner may withhold its next byte before the
//                  frame is aborted; 0 disables the timeout
// Ports
//   clk          : system clock
//   reset        : asynchronous, active-high reset
//   req          : requester i has a valid byte on req_data[8i+7:8i]
//   req_data     : byte of each requester, packed 8 bits per requester
//   req_last     : byte of requester i is the last byte of its frame
//   req_ack      : one-cycle pulse, byte of the owner consumed
//   grant        : one-hot current owner, all zero when idle
//   tx_data      : byte to the UART transmitter, held until the next load
//   tx_start     : one-cycle pulse, transmitter loads tx_data
//   tx_busy      : transmitter busy, rises at most 1 cycle after tx_start
//   frame_done   : one-cycle pulse, frame completed normally
//   frame_abort  : one-cycle pulse, frame aborted by timeout
// Build option
//   UART_TX_ARB_ID_HDR_EN : when defined, every grant first transmits the
//                  header byte 8'hA0 | owner index before the payload.
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   frame_done,
    output logic                   frame_abort
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int c_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Counter must be able to hold the value IDLE_TIMEOUT itself.
    localparam int c_TO_W   = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit c_TO_EN  = (IDLE_TIMEOUT > 0);
    // The abort fires on the cycle whose increment would reach IDLE_TIMEOUT.
    localparam logic [c_TO_W-1:0] c_TO_LAST =
        c_TO_W'((IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_SEND      = 2'd1;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd3;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  r_last_owner;
    logic                r_last_flag;
    logic [c_TO_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;
    logic                r_frame_done;
    logic                r_frame_abort;

    //--------------------------------------------------------------------------
    // Combinational signals
    //--------------------------------------------------------------------------
    logic [1:0]          w_state_nxt;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_win;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic                w_owner_req;
    logic                w_owner_last;
    logic [7:0]          w_owner_data;
    logic [NUM_REQ-1:0]  w_owner_onehot;
    logic [7:0]          w_hdr_byte;
    logic                w_hdr_pending;
    logic                w_grant_now;
    logic                w_load_hdr;
    logic                w_load_pay;
    logic                w_load;
    logic                w_cnt_run;
    logic                w_timeout;
    logic                w_finish;

    //--------------------------------------------------------------------------
    // Round-robin search: first set req bit starting just after the previous
    // owner, wrapping around. Only consulted in IDLE.
    //--------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[(int'(r_last_owner) + 1 + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_win   = c_IDX_W'((int'(r_last_owner) + 1 + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_win_onehot[i] = (w_win == c_IDX_W'(i));
        end
    end

    //--------------------------------------------------------------------------
    // Owner slice selection (mux written as a loop so non power-of-two
    // NUM_REQ never indexes beyond the packed vectors).
    //--------------------------------------------------------------------------
    always_comb begin
        w_owner_req    = 1'b0;
        w_owner_last   = 1'b0;
        w_owner_data   = 8'h00;
        w_owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == c_IDX_W'(i)) begin
                w_owner_req       = req[i];
                w_owner_last      = req_last[i];
                w_owner_data      = req_data[8*i +: 8];
                w_owner_onehot[i] = 1'b1;
            end
        end
    end

    assign w_hdr_byte = 8'hA0 | 8'(r_owner);

    //--------------------------------------------------------------------------
    // Optional identification header
    //--------------------------------------------------------------------------
`ifdef UART_TX_ARB_ID_HDR_EN
    logic r_hdr_pending;

    // Armed on every grant, consumed by the first load of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr_pending <= 1'b0;
        end else if (w_grant_now) begin
            r_hdr_pending <= 1'b1;
        end else if (w_load_hdr) begin
            r_hdr_pending <= 1'b0;
        end
    end

    assign w_hdr_pending = r_hdr_pending;
`else
    assign w_hdr_pending = 1'b0;
`endif

    //--------------------------------------------------------------------------
    // FSM process 1: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM process 2: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_now) begin
                    w_state_nxt = c_ST_SEND;
                end
            end
            c_ST_SEND: begin
                if (w_load) begin
                    w_state_nxt = c_ST_WAIT_BUSY;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            // Covers the transmitter's busy-rise latency; tx_busy is not
            // trustworthy in this cycle.
            c_ST_WAIT_BUSY: begin
                w_state_nxt = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = r_last_flag ? c_ST_IDLE : c_ST_SEND;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM process 3: output / action decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_grant_now = (r_state == c_ST_IDLE) && w_found;
        w_load_hdr  = (r_state == c_ST_SEND) && w_hdr_pending && !tx_busy;
        w_load_pay  = (r_state == c_ST_SEND) && !w_hdr_pending &&
                      w_owner_req && !tx_busy;
        w_load      = w_load_hdr || w_load_pay;
        // The counter only runs while the owner withholds data; a pending
        // byte blocked by tx_busy holds the count.
        w_cnt_run   = c_TO_EN && (r_state == c_ST_SEND) &&
                      !w_hdr_pending && !w_owner_req;
        w_timeout   = w_cnt_run && (r_cnt == c_TO_LAST);
        w_finish    = (r_state == c_ST_WAIT_DONE) && !tx_busy && r_last_flag;
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner       <= '0;
            r_last_owner  <= c_IDX_W'(NUM_REQ - 1);
            r_last_flag   <= 1'b0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_req_ack     <= '0;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            r_req_ack     <= '0;
            r_tx_start    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;

            if (w_grant_now) begin
                r_owner <= w_win;
                r_grant <= w_win_onehot;
            end

            // tx_start, tx_data and req_ack become visible together in the
            // following cycle, so the transmitter samples a stable byte.
            if (w_load) begin
                r_tx_data   <= w_load_hdr ? w_hdr_byte : w_owner_data;
                r_tx_start  <= 1'b1;
                r_req_ack   <= w_load_pay ? w_owner_onehot : '0;
                r_last_flag <= w_load_pay && w_owner_last;
            end

            if (w_grant_now || w_load || w_timeout) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + c_TO_W'(1);
            end

            if (w_timeout) begin
                r_frame_abort <= 1'b1;
                r_last_owner  <= r_owner;
                r_grant       <= '0;
            end

            if (w_finish) begin
                r_frame_done <= 1'b1;
                r_last_owner <= r_owner;
                r_grant      <= '0;
            end
        end
    end

    assign req_ack     = r_req_ack;
    assign grant       = r_grant;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//            IDLE_TIMEOUT=8) with queue-based requesters and a transmitter
//            model that stays busy for BUSY_LEN cycles after each tx_start.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int TO       = 8;
    localparam int BUSY_LEN = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR-1:0]      req;
    logic [8*NR-1:0]    req_data;
    logic [NR-1:0]      req_last;
    logic [NR-1:0]      req_ack;
    logic [NR-1:0]      grant;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic               frame_done;
    logic               frame_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    // Requester queues: {last, data}
    logic [8:0]     rq_mem [NR][8];
    int             rq_head [NR];
    int             rq_len  [NR];

    // Observation logs
    int             cyc;
    int             busy_left;
    bit             busy_force;
    logic [7:0]     sent_data  [$];
    logic [NR-1:0]  sent_grant [$];
    logic [NR-1:0]  sent_ack   [$];
    int             grant_log  [$];
    int             grant_cyc  [$];
    logic [NR-1:0]  prev_grant;
    int             start_cyc;
    int             done_cnt, abort_cnt, done_cyc, abort_cyc;
    int             ack_bad = 0;
    int             start_while_busy = 0;

    int             errors = 0;
    int             checks = 0;

    function automatic int oh_idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            if (rq_head[i] < rq_len[i]) begin
                req[i]             = 1'b1;
                req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
                req_last[i]        = rq_mem[i][rq_head[i]][8];
            end else begin
                req[i]             = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        rq_mem[r][rq_len[r]] = {l, d};
        rq_len[r]++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_len[i]  = 0;
        end
        sent_data.delete();
        sent_grant.delete();
        sent_ack.delete();
        grant_log.delete();
        grant_cyc.delete();
        prev_grant = '0;
        start_cyc  = 0;
        done_cnt   = 0;
        abort_cnt  = 0;
        done_cyc   = 0;
        abort_cyc  = 0;
        busy_left  = 0;
        busy_force = 1'b0;
        tx_busy    = 1'b0;
    endtask

    // One clock: sample just after the edge, log, model requesters/transmitter.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            if (tx_busy) start_while_busy++;
            sent_data.push_back(tx_data);
            sent_grant.push_back(grant);
            sent_ack.push_back(req_ack);
            start_cyc = cyc;
        end
        if (req_ack != '0) begin
            if (req_ack != grant || !tx_start) ack_bad++;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i] && rq_head[i] < rq_len[i]) rq_head[i]++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (grant != '0 && grant != prev_grant) begin
            grant_log.push_back(oh_idx(grant));
            grant_cyc.push_back(cyc);
        end
        prev_grant = grant;
        if (busy_force) begin
            tx_busy = 1'b1;
        end else if (tx_start) begin
            tx_busy   = 1'b1;
            busy_left = BUSY_LEN;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end else begin
            tx_busy = 1'b0;
        end
        drive_inputs();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_abort(input int n, input int budget);
        int k = 0;
        while (abort_cnt < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic wait_sent(input int n, input int budget);
        int k = 0;
        while (sent_data.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic do_reset(input bit hold_busy);
        reset = 1'b1;
        clear_model();
        busy_force = hold_busy;
        tx_busy    = hold_busy;
        drive_inputs();
        step();
        step();
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        cyc   = 0;
        clear_model();
        push_byte(2, 8'h5A, 1'b1);
        drive_inputs();
        step();
        step();
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant: got %b expected 0000", grant);
        end
        checks++;
        if (req_ack !== 4'b0000) begin
            errors++; $display("FAIL reset_ack: got %b expected 0000", req_ack);
        end
        checks++;
        if ({tx_start, frame_done, frame_abort} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000",
                               {tx_start, frame_done, frame_abort});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        wait_done(1, 60);
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL single_done: got %0d expected 1", done_cnt);
        end
        checks++;
        if (grant_log.size() < 1 || grant_log[0] !== 2) begin
            errors++; $display("FAIL single_grant: got %0d entries expected owner 2", grant_log.size());
        end
        checks++;
        if (sent_data.size() != 1 || sent_data[0] !== 8'h5A) begin
            errors++; $display("FAIL single_byte: got %0d bytes expected one 5a", sent_data.size());
        end
        checks++;
        if (sent_ack.size() != 1 || sent_ack[0] !== 4'b0100 || sent_grant[0] !== 4'b0100) begin
            errors++; $display("FAIL single_ack: got %0d starts expected ack/grant 0100", sent_ack.size());
        end
        checks++;
        if (grant_cyc.size() < 1 || start_cyc - grant_cyc[0] !== 1) begin
            errors++; $display("FAIL single_latency: got start %0d expected grant+1", start_cyc);
        end
        checks++;
        if (done_cyc - start_cyc !== BUSY_LEN + 1) begin
            errors++; $display("FAIL single_done_time: got %0d expected %0d",
                               done_cyc - start_cyc, BUSY_LEN + 1);
        end
        checks++;
        if (grant !== 4'b0000) begin
            errors++; $display("FAIL single_grant_clear: got %b expected 0000", grant);
        end
    endtask

    task automatic test_two_frames();
        logic [7:0]    exp_b [6];
        logic [NR-1:0] exp_g [6];
        clear_model();
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
        for (int k = 0; k < 6; k++) exp_g[k] = (k < 3) ? 4'b0001 : 4'b0010;
        push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
        push_byte(1, 8'h44, 1'b0); push_byte(1, 8'h55, 1'b0); push_byte(1, 8'h66, 1'b1);
        drive_inputs();
        wait_done(2, 300);
        checks++;
        if (sent_data.size() != 6) begin
            errors++; $display("FAIL two_count: got %0d expected 6", sent_data.size());
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= sent_data.size() || sent_data[k] !== exp_b[k] || sent_grant[k] !== exp_g[k]) begin
                errors++; $display("FAIL two_byte%0d: expected data %h grant %b", k, exp_b[k], exp_g[k]);
            end
        end
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin
            errors++; $display("FAIL two_grant_seq: got %0d grants expected 0,1", grant_log.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_o [6];
        do_reset(1'b0);
        for (int i = 0; i < NR; i++) begin
            push_byte(i, 8'(16*i + 1), 1'b1);
            push_byte(i, 8'(16*i + 2), 1'b1);
        end
        drive_inputs();
        reset = 1'b0;
        exp_o[0] = 0; exp_o[1] = 1; exp_o[2] = 2; exp_o[3] = 3; exp_o[4] = 0; exp_o[5] = 1;
        wait_done(8, 400);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= grant_log.size() || grant_log[k] !== exp_o[k] ||
                k >= sent_data.size() || sent_data[k] !== 8'(16*exp_o[k] + 1 + k/4)) begin
                errors++; $display("FAIL rr_order%0d: expected owner %0d", k, exp_o[k]);
            end
        end
        checks++;
        if (done_cnt !== 8) begin
            errors++; $display("FAIL rr_done: got %0d expected 8", done_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_model();
        push_byte(1, 8'h77, 1'b0);
        push_byte(2, 8'h88, 1'b1);
        drive_inputs();
        wait_abort(1, 100);
        checks++;
        if (abort_cnt !== 1) begin
            errors++; $display("FAIL to_abort: got %0d expected 1", abort_cnt);
        end
        checks++;
        if (sent_data.size() != 1 || sent_data[0] !== 8'h77 || abort_cyc - start_cyc !== BUSY_LEN + 1 + TO) begin
            errors++; $display("FAIL to_time: got %0d expected %0d",
                               abort_cyc - start_cyc, BUSY_LEN + 1 + TO);
        end
        checks++;
        if (grant !== 4'b0000 || done_cnt !== 0) begin
            errors++; $display("FAIL to_clear: got grant %b done %0d expected 0000/0", grant, done_cnt);
        end
        wait_done(1, 100);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 1 || grant_log[1] !== 2 ||
            sent_data.size() != 2 || sent_data[1] !== 8'h88) begin
            errors++; $display("FAIL to_next: got %0d grants %0d bytes expected owner 2 byte 88",
                               grant_log.size(), sent_data.size());
        end
    endtask

    task automatic test_busy_hold();
        int f;
        do_reset(1'b1);
        push_byte(0, 8'h3C, 1'b1);
        drive_inputs();
        reset = 1'b0;
        for (int k = 0; k < 100; k++) step();
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL busy_grant: got %b expected 0001", grant);
        end
        checks++;
        if (sent_data.size() != 0) begin
            errors++; $display("FAIL busy_no_start: got %0d starts expected 0", sent_data.size());
        end
        busy_force = 1'b0;
        tx_busy    = 1'b0;
        f = cyc;
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h3C || cyc != f + 1) begin
            errors++; $display("FAIL busy_release: got start %b data %h expected 1/3c", tx_start, tx_data);
        end
        wait_done(1, 60);
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL busy_done: got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset(1'b0);
        push_byte(1, 8'hA1, 1'b0); push_byte(1, 8'hA2, 1'b0); push_byte(1, 8'hA3, 1'b1);
        drive_inputs();
        reset = 1'b0;
        wait_sent(2, 100);
        step();
        step();
        checks++;
        if (grant !== 4'b0010 || tx_data !== 8'hA2) begin
            errors++; $display("FAIL mid_pre: got grant %b data %h expected 0010/a2", grant, tx_data);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({grant, req_ack, tx_start, frame_done, frame_abort, tx_data} !== '0) begin
            errors++; $display("FAIL mid_async_zero: got grant %b data %h expected all zero", grant, tx_data);
        end
        clear_model();
        push_byte(3, 8'hC3, 1'b1);
        push_byte(0, 8'hC0, 1'b1);
        drive_inputs();
        step();
        step();
        reset = 1'b0;
        wait_done(2, 200);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 0 || grant_log[1] !== 3) begin
            errors++; $display("FAIL mid_regrant: got %0d grants expected 0 then 3", grant_log.size());
        end
        checks++;
        if (sent_data.size() != 2 || sent_data[0] !== 8'hC0 || sent_data[1] !== 8'hC3) begin
            errors++; $display("FAIL mid_bytes: got %0d bytes expected c0,c3", sent_data.size());
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (ack_bad !== 0) begin
            errors++; $display("FAIL proto_ack: got %0d bad acks expected 0", ack_bad);
        end
        checks++;
        if (start_while_busy !== 0) begin
            errors++; $display("FAIL proto_start_busy: got %0d expected 0", start_while_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_frames();
        test_round_robin();
        test_timeout();
        test_busy_hold();
        test_reset_mid_frame();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter between NUM_REQ requesters, such as the per-channel acoustics reporters and the command-response path.
Grants are frame-locked: the owner keeps the transmitter until it sends a byte flagged last, or until it goes idle past a timeout.
Sits between the requester blocks and the UART TX datapath. Sequences the transmitter via a tx_start/tx_busy handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
IDLE_TIMEOUT, 1024, cycles the owner may withhold its next byte before the frame is aborted; 0 disables the timeout

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  requester i has a valid byte on its slice of req_data
req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
req_last  input  NUM_REQ  byte of requester i is the last byte of its frame
req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i consumed
grant  output  NUM_REQ  one-hot current owner; all zero when idle
tx_data  output  8  byte to the UART transmitter; held until the next load
tx_start  output  1  one-cycle pulse: transmitter loads tx_data
tx_busy  input  1  transmitter busy; rises no later than 1 cycle after tx_start
frame_done  output  1  one-cycle pulse: frame completed normally
frame_abort  output  1  one-cycle pulse: frame aborted by timeout

Behaviour:
- Reset (async, active-high): state IDLE; grant, req_ack, tx_start, frame_done, frame_abort, tx_data all 0; last_owner = NUM_REQ-1, so requester 0 wins first. Reset mid-frame drops the frame immediately and issues no ack.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req bit is set, pick the first set bit searching from (last_owner+1) mod NUM_REQ upward with wrap. Register grant; go to SEND on the next cycle. Arbitration takes 1 cycle.
- SEND:
  - If req[owner] && !tx_busy: latch req_data slice into tx_data and pulse tx_start; pulse req_ack[owner] in the same cycle; latch req_last[owner] into last_flag; clear the timeout counter; go to WAIT_BUSY.
  - If req[owner] is high while tx_busy is high: wait; the timeout counter does not advance.
- WAIT_BUSY: 1 cycle unconditional, covering the transmitter's busy-rise latency; go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy low.
  - If last_flag: pulse frame_done, last_owner <= owner, grant <= 0, go to IDLE.
  - Otherwise go to SEND.
- Timeout: in SEND with req[owner] low, the counter increments each cycle. When it reaches IDLE_TIMEOUT: pulse frame_abort, last_owner <= owner, grant <= 0, go to IDLE. Counter width is clog2(IDLE_TIMEOUT+1).
- Non-owner requests are ignored during a frame; they are not acked and not lost, and are re-arbitrated in IDLE.
- Minimum spacing: the earliest back-to-back tx_start pulses within a frame are 3 cycles apart, plus the transmitter's busy time.
- Only the owner's req_ack bit can ever pulse; at most one tx_start per byte.
- A req_last byte while already the final byte is acked normally; the frame completes normally.

Optional Feature:
Macro UART_TX_ARB_ID_HDR_EN.
- Defined: after each grant, the arbiter first transmits header byte 8'hA0 | owner index (4 bits). This uses the same SEND/WAIT_BUSY/WAIT_DONE sequence but does not require req and does not pulse req_ack. Payload bytes follow. The timeout starts only after the header completes.
- Undefined: no header; the first transmitted byte is the first payload byte.

Test Plan:
- Reset released, req[2]=1, data 8'h5A, last=1, tx_busy models 10-cycle busy -> grant=4'b0100; one tx_start with tx_data=8'h5A and req_ack[2] in the same cycle; frame_done after tx_busy falls; grant=0.
- req[0] and req[1] asserted together, 3-byte frames 11/22/33 and 44/55/66 -> bytes sent in order 11,22,33,44,55,66; grant never switches mid-frame.
- All 4 requesters continuously requesting single-byte frames -> grant sequence 0,1,2,3,0,1.
- IDLE_TIMEOUT=8: owner 1 sends a non-last byte, then drops req -> frame_abort exactly 8 cycles after entering SEND with req low; grant cleared; pending requester 2 served next.
- tx_busy held high for 100 cycles after reset with req[0] set -> grant=4'b0001 but no tx_start until tx_busy falls, then tx_start within 1 cycle.
- Reset asserted during WAIT_DONE of a 3-byte frame -> all outputs 0 asynchronously; after release with req[3] and req[0] pending, requester 0 is granted first.
